obi_mem_responder: RTL

// - Memory-side responder for the core's OBI-style req/gnt/rvalid instruction or data port (instantiate one per port).
// - Generates gnt/rvalid under external stall control with bounded waits, backed by a small byte-enable RAM.
// - Tracks outstanding transactions and flags initiator protocol violations.
// - Sits in the formal wrapper and sim benches in place of free-running rvformal_rand_reg handshake inputs.

---
 rtl/obi_mem_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : obi_mem_responder
// Description : OBI-style memory responder with bounded gnt/rvalid stalls,
//               byte-enable RAM, in-order response FIFO and violation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_mem_responder #(
    parameter int MEM_WORDS       = 256,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_STALL       = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 req_i,
    input  logic [31:0]                          addr_i,
    input  logic                                 we_i,
    input  logic [3:0]                           be_i,
    input  logic [31:0]                          wdata_i,
    output logic                                 gnt_o,
    output logic                                 rvalid_o,
    output logic [31:0]                          rdata_o,
    output logic                                 err_o,
    input  logic                                 stall_gnt_i,
    input  logic                                 stall_rvalid_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 viol_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int WAIT_W = $clog2(MAX_STALL + 1);
    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WAIT_W-1:0] STALL_MAX = WAIT_W'(MAX_STALL);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [29:0]       WORDS_LIM = 30'(MEM_WORDS);

    logic [31:0]       mem [MEM_WORDS];
    logic [32:0]       fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] gnt_wait;
    logic [WAIT_W-1:0] rsp_wait;
    logic              pend_q;
    logic [68:0]       req_q;
    logic              viol;

    logic              full;
    logic              empty;
    logic              in_range;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;
    logic [32:0]       push_entry;
    logic [32:0]       head;
    logic [68:0]       req_now;
    logic              gnt;
    logic              rvalid;

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign in_range = (addr_i[31:2] < WORDS_LIM);
    assign word_idx = addr_i[IDX_W+1:2];
    assign rd_word  = in_range ? mem[word_idx] : 32'h0;
    assign head     = fifo[rd_ptr];
    assign req_now  = {addr_i, we_i, be_i, wdata_i};

    // Reset forces both handshakes low so in-flight entries are silently dropped.
    assign gnt    = !reset && req_i && !full && (!stall_gnt_i || gnt_wait == STALL_MAX);
    assign rvalid = !reset && !empty && (!stall_rvalid_i || rsp_wait == STALL_MAX);

    always_comb begin
        wr_word = rd_word;
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
                wr_word[8*k +: 8] = wdata_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        push_entry = 33'h0;
        if (!in_range) begin
            push_entry = {1'b1, 32'h0};
        end else if (!we_i) begin
            push_entry = {1'b0, rd_word};
        end
    end

    assign gnt_o         = gnt;
    assign rvalid_o      = rvalid;
    assign rdata_o       = rvalid ? head[31:0] : 32'h0;
    assign err_o         = rvalid & head[32];
    assign outstanding_o = count;
    assign viol_o        = viol;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (gnt && we_i && in_range) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (gnt) begin
            fifo[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (gnt) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rvalid) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({gnt, rvalid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_wait <= '0;
            rsp_wait <= '0;
        end else begin
            // A full FIFO holds the grant counter rather than advancing it.
            if (gnt || !req_i) begin
                gnt_wait <= '0;
            end else if (!full && gnt_wait != STALL_MAX) begin
                gnt_wait <= gnt_wait + 1'b1;
            end
            if (rvalid) begin
                rsp_wait <= '0;
            end else if (!empty && rsp_wait != STALL_MAX) begin
                rsp_wait <= rsp_wait + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= 1'b0;
            req_q  <= '0;
            viol   <= 1'b0;
        end else begin
            pend_q <= req_i & !gnt;
            req_q  <= req_now;
            if (pend_q && (!req_i || req_q != req_now)) begin
                viol <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
